// File: rtl/membus_pkg.sv
// Shared definitions for the multi-port membus core memory: cycle states,
// select-code width, default select map and a small sizing helper.
package membus_pkg;

    // Width of one module-select code on the bus.
    localparam int SEL_W = 4;

    // Default select map: every port answers to select code 0.
    localparam logic [15:0] MEMSEL_DEFAULT = 16'h0000;

    // Phases of one membus cycle as seen by the memory.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACK     = 3'd1,
        S_RD      = 3'd2,
        S_RESTORE = 3'd3,
        S_WAITWR  = 3'd4,
        S_WRITE   = 3'd5,
        S_RELEASE = 3'd6
    } mb_state_e;

    // Largest of three values; sizes the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/membus_arb.sv
// Port arbiter: picks one eligible port, either lowest index first or
// round-robin starting at a pointer that moves past each winner.
module membus_arb #(
    parameter int NPORTS  = 4,
    parameter int RR_MODE = 0,
    parameter int IDX_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NPORTS-1:0] i_elig,
    input  logic              i_grant_stb,
    output logic [NPORTS-1:0] o_grant,
    output logic [IDX_W-1:0]  o_grant_idx,
    output logic              o_any
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W:0]   w_sum  [NPORTS];
    logic [IDX_W-1:0] w_cand [NPORTS];
    logic [IDX_W-1:0] w_idx;
    logic             w_any;

    // Candidate order: slot k is the k-th port to consider this cycle.
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_cand
            assign w_sum[gi]  = {1'b0, r_ptr} + (IDX_W+1)'(gi);
            assign w_cand[gi] = (RR_MODE == 0) ? IDX_W'(gi) :
                                (w_sum[gi] >= (IDX_W+1)'(NPORTS)) ?
                                    IDX_W'(w_sum[gi] - (IDX_W+1)'(NPORTS)) :
                                    w_sum[gi][IDX_W-1:0];
            assign o_grant[gi] = w_any && (w_idx == IDX_W'(gi));
        end
    endgenerate

    // First eligible candidate wins; scanning downwards lets slot 0 overwrite last.
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            if (i_elig[w_cand[k]]) begin
                w_any = 1'b1;
                w_idx = w_cand[k];
            end
        end
    end

    assign o_grant_idx = w_idx;
    assign o_any       = w_any;

    // Round-robin pointer advances to the port after the winner on each grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if ((RR_MODE != 0) && i_grant_stb && w_any) begin
            r_ptr <= (w_idx == IDX_W'(NPORTS - 1)) ? '0 : w_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/membus_core_mem.sv
// Multi-port KA10 membus core memory. One cycle at a time is served:
// acknowledge, optional read with restart, optional write-back, then release.
// All outputs are zero when idle so several instances can be OR-merged.
import membus_pkg::*;

module membus_core_mem #(
    parameter int          NPORTS  = 4,
    parameter int          ADDR_W  = 15,
    parameter int          WORD_W  = 36,
    parameter logic [15:0] MEMSEL  = MEMSEL_DEFAULT,
    parameter int          RR_MODE = 0,
    parameter int          RD_LAT  = 3,
    parameter int          WR_LAT  = 2,
    parameter int          TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     power,
    input  logic [NPORTS-1:0]        membus_rq_cyc,
    input  logic [NPORTS-1:0]        membus_rd_rq,
    input  logic [NPORTS-1:0]        membus_wr_rq,
    input  logic [NPORTS-1:0]        membus_wr_rs,
    input  logic [NPORTS-1:0]        membus_fmc_select,
    input  logic [SEL_W*NPORTS-1:0]  membus_sel,
    input  logic [ADDR_W*NPORTS-1:0] membus_ma,
    input  logic [WORD_W*NPORTS-1:0] membus_mb_in,
    output logic [NPORTS-1:0]        membus_addr_ack,
    output logic [NPORTS-1:0]        membus_rd_rs,
    output logic [WORD_W*NPORTS-1:0] membus_mb_out,
    output logic                     busy,
    output logic                     err_timeout
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int IDX_W   = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int CNT_MAX = max3(RD_LAT, WR_LAT, TIMEOUT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Core array: contents survive reset.
    logic [WORD_W-1:0] r_core [DEPTH];

    mb_state_e         r_state;
    mb_state_e         w_state_next;
    logic [IDX_W-1:0]  r_gnt;
    logic [ADDR_W-1:0] r_ma;
    logic              r_rd_req;
    logic              r_wr_req;
    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_rdata;
    logic [WORD_W-1:0] r_wdata;
    logic              r_rd_valid;
    logic              r_rd_rs;

    logic [NPORTS-1:0] w_elig;
    logic [NPORTS-1:0] w_arb_onehot;
    logic [IDX_W-1:0]  w_arb_idx;
    logic              w_arb_any;
    logic              w_grant;
    logic [ADDR_W-1:0] w_ma_port    [NPORTS];
    logic [WORD_W-1:0] w_mb_in_port [NPORTS];
    logic              w_wr_rs_g;
    logic              w_rq_cyc_g;
    logic              w_rd_fire;
    logic              w_wr_fire;
    logic              w_wr_capture;
    logic              w_timeout;
    logic              w_core_we;

    // Per-port request decode and output steering.
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
            assign w_elig[gi] = power & membus_rq_cyc[gi] & ~membus_fmc_select[gi]
                              & (membus_sel[gi*SEL_W +: SEL_W] == MEMSEL[gi*SEL_W +: SEL_W])
                              & (membus_rd_rq[gi] | membus_wr_rq[gi]);
            assign w_ma_port[gi]    = membus_ma[gi*ADDR_W +: ADDR_W];
            assign w_mb_in_port[gi] = membus_mb_in[gi*WORD_W +: WORD_W];

            assign membus_addr_ack[gi] = (r_state == S_ACK) && (r_gnt == IDX_W'(gi));
            assign membus_rd_rs[gi]    = r_rd_rs && (r_gnt == IDX_W'(gi));
            assign membus_mb_out[gi*WORD_W +: WORD_W] =
                (r_rd_valid && (r_gnt == IDX_W'(gi))) ? r_rdata : '0;
        end
    endgenerate

    membus_arb #(
        .NPORTS  (NPORTS),
        .RR_MODE (RR_MODE),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .i_elig      (w_elig),
        .i_grant_stb (w_grant),
        .o_grant     (w_arb_onehot),
        .o_grant_idx (w_arb_idx),
        .o_any       (w_arb_any)
    );

    assign w_grant    = (r_state == S_IDLE) && w_arb_any;
    assign w_wr_rs_g  = membus_wr_rs[r_gnt];
    assign w_rq_cyc_g = membus_rq_cyc[r_gnt];
    assign w_core_we  = w_wr_fire & ~reset;

    assign busy        = (r_state != S_IDLE);
    assign err_timeout = w_timeout;

    // Next phase of the cycle plus the single-cycle strobes that act on the core.
    always_comb begin
        w_state_next = r_state;
        w_rd_fire    = 1'b0;
        w_wr_fire    = 1'b0;
        w_wr_capture = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_arb_any) w_state_next = S_ACK;
            end
            S_ACK: begin
                w_state_next = r_rd_req ? S_RD : S_WAITWR;
            end
            S_RD: begin
                if (r_cnt == CNT_W'(RD_LAT - 1)) begin
                    w_rd_fire    = 1'b1;
                    w_state_next = r_wr_req ? S_WAITWR : S_RESTORE;
                end
            end
            S_RESTORE: begin
                if (r_cnt == CNT_W'(WR_LAT - 1)) w_state_next = S_RELEASE;
            end
            S_WAITWR: begin
                if (w_wr_rs_g) begin
                    w_wr_capture = 1'b1;
                    w_state_next = S_WRITE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_RELEASE;
                end
            end
            S_WRITE: begin
                if (r_cnt == CNT_W'(WR_LAT - 1)) begin
                    w_wr_fire    = 1'b1;
                    w_state_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!w_rq_cyc_g) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Cycle bookkeeping: phase, per-phase counter, latched request and data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_ma       <= '0;
            r_rd_req   <= 1'b0;
            r_wr_req   <= 1'b0;
            r_cnt      <= '0;
            r_wdata    <= '0;
            r_rd_valid <= 1'b0;
            r_rd_rs    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= (w_state_next != r_state) ? '0 : r_cnt + CNT_W'(1);
            r_rd_rs <= w_rd_fire;
            if (w_grant) begin
                r_gnt    <= w_arb_idx;
                r_ma     <= w_ma_port[w_arb_idx];
                r_rd_req <= |(w_arb_onehot & membus_rd_rq);
                r_wr_req <= |(w_arb_onehot & membus_wr_rq);
            end
            if (w_wr_capture) r_wdata <= w_mb_in_port[r_gnt];
            if (w_rd_fire) begin
                r_rd_valid <= 1'b1;
            end else if (w_state_next == S_RELEASE) begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    // Core access: registered read at the end of the read delay, write-back at end of write.
    always_ff @(posedge clk) begin
        if (w_core_we) r_core[r_ma] <= r_wdata;
        if (w_rd_fire) r_rdata <= r_core[r_ma];
    end

endmodule
